// File: rtl/ps2_key_event_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_event_decoder
//
// Purpose:
//   Turns the raw PS/2 set-2 scan-code byte stream from PS2_Controller into
//   one-cycle game actions (hit / stand / deal) for the blackjack FSM.
//   It does the following:
//     - decodes the make, break (F0) and extended (E0, E0 F0) sequences;
//     - fires an action only on the first make of a key, so typematic repeats
//       are ignored;
//     - enforces a minimum spacing between accepted actions (lockout);
//     - discards a dangling F0/E0 prefix if the following code byte never
//       arrives (prefix timeout).
//
// Ports:
//   CLOCK_50          in   1  system clock (50 MHz)
//   reset             in   1  asynchronous, active-high reset
//   received_data     in   8  scan-code byte from PS2_Controller
//   received_data_en  in   1  one-cycle strobe, received_data valid
//   hit_pulse         out  1  one-cycle pulse, hit action accepted
//   stand_pulse       out  1  one-cycle pulse, stand action accepted
//   deal_pulse        out  1  one-cycle pulse, deal action accepted
//   key_held          out  3  {deal,stand,hit} currently held down
//   last_code         out  8  last non-prefix, non-extended code decoded
//   lockout_active    out  1  high while the lockout counter is nonzero
// ---------------------------------------------------------------------------
module ps2_key_event_decoder #(
  parameter logic [7:0]  HIT_CODE       = 8'h33,
  parameter logic [7:0]  STAND_CODE     = 8'h1B,
  parameter logic [7:0]  DEAL_CODE      = 8'h23,
  parameter int unsigned LOCKOUT_CYCLES = 5_000_000,
  parameter int unsigned PREFIX_TIMEOUT = 2_500_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic       hit_pulse,
  output logic       stand_pulse,
  output logic       deal_pulse,
  output logic [2:0] key_held,
  output logic [7:0] last_code,
  output logic       lockout_active
);

  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam int PW = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [PW-1:0] PFX_LOAD  = PW'(PREFIX_TIMEOUT - 1);

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BRK     = 2'd1,
    S_EXT     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t          r_state;
  logic [LW-1:0]   r_lock;
  logic [PW-1:0]   r_pfx;

  logic [2:0]      w_key_sel;   // one-hot {deal,stand,hit} match of the byte
  logic            w_is_ext;
  logic            w_is_brk;

  assign w_key_sel = {received_data == DEAL_CODE,
                      received_data == STAND_CODE,
                      received_data == HIT_CODE};
  assign w_is_ext  = (received_data == CODE_EXT);
  assign w_is_brk  = (received_data == CODE_BRK);

  assign lockout_active = (r_lock != '0);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_lock      <= '0;
      r_pfx       <= '0;
      hit_pulse   <= 1'b0;
      stand_pulse <= 1'b0;
      deal_pulse  <= 1'b0;
      key_held    <= 3'b000;
      last_code   <= 8'h00;
    end else begin
      hit_pulse   <= 1'b0;
      stand_pulse <= 1'b0;
      deal_pulse  <= 1'b0;

      // Saturating countdown. A reload below (accepted action) overrides it.
      // A make arriving in the cycle the counter hits zero still sees the
      // nonzero value, so it is dropped.
      if (r_lock != '0)
        r_lock <= r_lock - LW'(1);

      if (received_data_en) begin
        case (r_state)
          S_IDLE: begin
            if (w_is_ext) begin
              r_state <= S_EXT;
              r_pfx   <= PFX_LOAD;
            end else if (w_is_brk) begin
              r_state <= S_BRK;
              r_pfx   <= PFX_LOAD;
            end else if (w_key_sel != 3'b000) begin
              // Key already down: this is typematic repeat, so ignore it.
              if ((key_held & w_key_sel) == 3'b000) begin
                key_held  <= key_held | w_key_sel;
                last_code <= received_data;
                if (r_lock == '0) begin
                  {deal_pulse, stand_pulse, hit_pulse} <= w_key_sel;
                  r_lock <= LOCK_LOAD;
                end
              end
            end else begin
              last_code <= received_data;
            end
          end
          // Any byte after F0 is the break code. An E0 or F0 byte here is also
          // taken as the code; prefixes do not nest.
          S_BRK: begin
            key_held  <= key_held & ~w_key_sel;
            last_code <= received_data;
            r_state   <= S_IDLE;
          end
          S_EXT: begin
            if (w_is_brk) begin
              r_state <= S_EXT_BRK;
              r_pfx   <= PFX_LOAD;
            end else begin
              r_state <= S_IDLE;   // extended make: not a game key
            end
          end
          default: begin
            r_state <= S_IDLE;     // extended break: ignored
          end
        endcase
      end else if (r_state != S_IDLE) begin
        // Stale prefix: give up after the timeout. A strobe in the expiry cycle
        // takes the branch above, so that byte is still decoded.
        if (r_pfx == '0)
          r_state <= S_IDLE;
        else
          r_pfx <= r_pfx - PW'(1);
      end
    end
  end

endmodule
